// File: rtl/frame_mux_pkg.sv
// Shared types and constants for the frame source multiplexer and the LED board driver.
// Also holds the source priority encoder.
package frame_mux_pkg;

  typedef enum logic {SHOW = 1'b0, BLANK = 1'b1} state_t;

  localparam int DEF_ROWS         = 16;
  localparam int DEF_COLS         = 16;
  localparam int BLANK_FRAMES_MAX = 15;
  localparam int PRIO_MAX_SRC     = 64;

  // Highest set index wins; an all-zero request vector selects source 0.
  function automatic int unsigned prio_enc(input logic [PRIO_MAX_SRC-1:0] en);
    prio_enc = 0;
    for (int unsigned i = 0; i < PRIO_MAX_SRC; i++) begin
      if (en[i]) prio_enc = i;
    end
  endfunction

endpackage

// File: rtl/frame_mux_blink_phase_gen.sv
// Free-running blink phase generator: counts frame ticks and toggles the phase every
// BLINK_PERIOD ticks. Phase is look-ahead, i.e. the value that holds after the current edge.
module blink_phase_gen #(
  parameter int BLINK_PERIOD = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic FrameTick,
  output logic Phase
);

  localparam int CW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

  logic [CW-1:0] cnt;
  logic          phase_q;
  logic          wrap;

  assign wrap  = FrameTick && (cnt == CW'(BLINK_PERIOD - 1));
  assign Phase = phase_q ^ wrap;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt     <= '0;
      phase_q <= 1'b1;
    end else if (FrameTick) begin
      cnt     <= wrap ? '0 : cnt + CW'(1);
      phase_q <= phase_q ^ wrap;
    end
  end

endmodule

// File: rtl/frame_mux.sv
// Priority frame source selector with frame-aligned switching and a blank interval.
// Optional blinking per source is enabled with the FRAME_MUX_BLINK_EN macro.
module frame_mux
  import frame_mux_pkg::*;
#(
  parameter int ROWS         = DEF_ROWS,
  parameter int COLS         = DEF_COLS,
  parameter int NSRC         = 4,
  parameter int BLANK_FRAMES = 2,
  parameter int BLINK_PERIOD = 8
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic [NSRC-1:0][ROWS-1:0][COLS-1:0]   SrcRed,
  input  logic [NSRC-1:0][ROWS-1:0][COLS-1:0]   SrcGrn,
  input  logic [NSRC-1:0]                       SrcEn,
  input  logic                                  FrameTick,
`ifdef FRAME_MUX_BLINK_EN
  input  logic [NSRC-1:0]                       BlinkMask,
`endif
  output logic [ROWS-1:0][COLS-1:0]             RedPixels,
  output logic [ROWS-1:0][COLS-1:0]             GrnPixels,
  output logic [$clog2(NSRC)-1:0]               Active,
  output logic                                  Switching
);

  localparam int AW = $clog2(NSRC);

  if (NSRC < 2 || NSRC > PRIO_MAX_SRC) begin : g_bad_nsrc
    $error("frame_mux: NSRC out of range");
  end
  if (BLANK_FRAMES < 0 || BLANK_FRAMES > BLANK_FRAMES_MAX) begin : g_bad_blank
    $error("frame_mux: BLANK_FRAMES out of range");
  end
  if (BLINK_PERIOD < 1) begin : g_bad_blink
    $error("frame_mux: BLINK_PERIOD must be at least 1");
  end

  state_t                   state, state_n;
  logic [AW-1:0]            cur, cur_n, pend, pend_n, req;
  logic [3:0]               bcnt, bcnt_n;
  logic [ROWS-1:0][COLS-1:0] red_n, grn_n;
  logic                     blink_on;

  assign req = AW'(prio_enc(PRIO_MAX_SRC'(SrcEn)));

`ifdef FRAME_MUX_BLINK_EN
  logic phase;

  blink_phase_gen #(.BLINK_PERIOD(BLINK_PERIOD)) u_blink (
    .CLK       (CLK),
    .RST       (RST),
    .FrameTick (FrameTick),
    .Phase     (phase)
  );

  assign blink_on = !BlinkMask[cur_n] || phase;
`else
  assign blink_on = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= SHOW;
      cur       <= '0;
      pend      <= '0;
      bcnt      <= '0;
      RedPixels <= '0;
      GrnPixels <= '0;
    end else begin
      state     <= state_n;
      cur       <= cur_n;
      pend      <= pend_n;
      bcnt      <= bcnt_n;
      RedPixels <= red_n;
      GrnPixels <= grn_n;
    end
  end

  // Requests are only looked at on frame ticks; the blank interval is never restarted.
  always_comb begin
    state_n = state;
    cur_n   = cur;
    pend_n  = pend;
    bcnt_n  = bcnt;
    case (state)
      SHOW: begin
        if (FrameTick && req != cur) begin
          if (BLANK_FRAMES > 0) begin
            pend_n  = req;
            bcnt_n  = 4'(BLANK_FRAMES);
            state_n = BLANK;
          end else begin
            cur_n = req;
          end
        end
      end
      BLANK: begin
        if (FrameTick) begin
          pend_n = req;
          bcnt_n = bcnt - 4'd1;
          if (bcnt == 4'd1) begin
            cur_n   = req;
            state_n = SHOW;
          end
        end
      end
      default: state_n = SHOW;
    endcase
  end

  // Planes follow the next state so data, Active and Switching move on the same edge.
  always_comb begin
    red_n = '0;
    grn_n = '0;
    if (state_n == SHOW && blink_on) begin
      red_n = SrcRed[cur_n];
      grn_n = SrcGrn[cur_n];
    end
  end

  assign Active    = cur;
  assign Switching = (state == BLANK);

endmodule

// File: tb/tb_frame_mux.sv
// Directed bench for frame_mux: one instance with a 2-frame blank and one with no blank,
// sharing all inputs. The blink sequence runs when FRAME_MUX_BLINK_EN is defined.
module tb_frame_mux;

  localparam int ROWS = 16;
  localparam int COLS = 16;
  localparam int NSRC = 4;
  localparam int AW   = 2;
  localparam int PW   = ROWS * COLS;

  logic                                CLK = 1'b0;
  logic                                RST;
  logic [NSRC-1:0][ROWS-1:0][COLS-1:0] SrcRed, SrcGrn;
  logic [NSRC-1:0]                     SrcEn;
  logic                                FrameTick;
  logic [ROWS-1:0][COLS-1:0]           red2, grn2, red0, grn0, snap;
  logic [AW-1:0]                       act2, act0;
  logic                                sw2, sw0;
`ifdef FRAME_MUX_BLINK_EN
  logic [NSRC-1:0]                     BlinkMask = '0;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  frame_mux #(.ROWS(ROWS), .COLS(COLS), .NSRC(NSRC), .BLANK_FRAMES(2), .BLINK_PERIOD(2)) dut (
    .CLK(CLK), .RST(RST), .SrcRed(SrcRed), .SrcGrn(SrcGrn), .SrcEn(SrcEn),
    .FrameTick(FrameTick),
`ifdef FRAME_MUX_BLINK_EN
    .BlinkMask(BlinkMask),
`endif
    .RedPixels(red2), .GrnPixels(grn2), .Active(act2), .Switching(sw2)
  );

  frame_mux #(.ROWS(ROWS), .COLS(COLS), .NSRC(NSRC), .BLANK_FRAMES(0), .BLINK_PERIOD(2)) dut0 (
    .CLK(CLK), .RST(RST), .SrcRed(SrcRed), .SrcGrn(SrcGrn), .SrcEn(SrcEn),
    .FrameTick(FrameTick),
`ifdef FRAME_MUX_BLINK_EN
    .BlinkMask(BlinkMask),
`endif
    .RedPixels(red0), .GrnPixels(grn0), .Active(act0), .Switching(sw0)
  );

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step(input logic tick);
    FrameTick = tick;
    @(posedge CLK);
    #1;
    FrameTick = 1'b0;
  endtask

  initial begin
    RST       = 1'b1;
    SrcEn     = '0;
    FrameTick = 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      for (int r = 0; r < ROWS; r++) begin
        SrcRed[s][r] = {4'hA, 4'(s), 4'h0, 4'(r)};
        SrcGrn[s][r] = {4'(r), 4'h5, 4'(s), 4'hC};
      end
    end

    // Reset
    step(0); step(0); step(0);
    check("rst_red", red2, PW'(0));
    check("rst_grn", grn2, PW'(0));
    check("rst_active", PW'(act2), PW'(0));
    check("rst_switching", PW'(sw2), PW'(0));
    check("rst_active_b0", PW'(act0), PW'(0));

    RST = 1'b0;
    step(0);
    check("post_rst_red", red2, SrcRed[0]);
    check("post_rst_grn", grn2, SrcGrn[0]);

    // Live data, one cycle of latency
    snap = SrcRed[0];
    SrcRed[0][3] = 16'h1234;
    check("latency_hold", red2, snap);
    step(0);
    check("latency_new", red2, SrcRed[0]);

    // Mid-frame request waits for the tick
    SrcEn = 4'b0100;
    step(0);
    check("midframe_active", PW'(act2), PW'(0));
    check("midframe_sw", PW'(sw2), PW'(0));
    check("midframe_red", red2, SrcRed[0]);
    check("midframe_active_b0", PW'(act0), PW'(0));

    // Switch tick: blank starts; the no-blank instance switches at once
    step(1);
    check("enter_sw", PW'(sw2), PW'(1));
    check("enter_red", red2, PW'(0));
    check("enter_grn", grn2, PW'(0));
    check("enter_active", PW'(act2), PW'(0));
    check("b0_active", PW'(act0), PW'(2));
    check("b0_red", red0, SrcRed[2]);
    check("b0_sw", PW'(sw0), PW'(0));
    step(0);
    check("blank_hold_sw", PW'(sw2), PW'(1));
    step(1);
    check("blank_tick1_sw", PW'(sw2), PW'(1));
    check("blank_tick1_red", red2, PW'(0));
    step(1);
    check("blank_done_sw", PW'(sw2), PW'(0));
    check("blank_done_active", PW'(act2), PW'(2));
    check("blank_done_red", red2, SrcRed[2]);
    check("blank_done_grn", grn2, SrcGrn[2]);

    // Priority and retarget during the blank
    SrcEn = 4'b1010;
    step(1);
    check("prio_sw", PW'(sw2), PW'(1));
    check("prio_active_hold", PW'(act2), PW'(2));
    check("prio_b0_active", PW'(act0), PW'(3));
    check("prio_b0_red", red0, SrcRed[3]);
    SrcEn = 4'b0010;
    step(1);
    check("retarget_sw", PW'(sw2), PW'(1));
    check("retarget_b0_active", PW'(act0), PW'(1));
    step(1);
    check("retarget_sw_done", PW'(sw2), PW'(0));
    check("retarget_active", PW'(act2), PW'(1));
    check("retarget_red", red2, SrcRed[1]);

    // Blank completes even when the request returns to the old source
    SrcEn = 4'b0000;
    step(1);
    check("return_enter_sw", PW'(sw2), PW'(1));
    check("return_b0_active", PW'(act0), PW'(0));
    SrcEn = 4'b0010;
    step(1);
    check("return_mid_sw", PW'(sw2), PW'(1));
    step(1);
    check("return_sw", PW'(sw2), PW'(0));
    check("return_active", PW'(act2), PW'(1));
    check("return_red", red2, SrcRed[1]);
    check("return_b0_active2", PW'(act0), PW'(1));

    // Reset aborts a blank and overrides a coincident tick
    SrcEn = 4'b0100;
    step(1);
    check("rst_mid_enter_sw", PW'(sw2), PW'(1));
    step(0);
    RST = 1'b1;
    step(1);
    check("rst_mid_sw", PW'(sw2), PW'(0));
    check("rst_mid_active", PW'(act2), PW'(0));
    check("rst_mid_red", red2, PW'(0));
    check("rst_mid_b0_active", PW'(act0), PW'(0));
    check("rst_mid_b0_red", red0, PW'(0));
    RST   = 1'b0;
    SrcEn = 4'b0000;
    step(0);
    check("rst_mid_after_red", red2, SrcRed[0]);
    check("rst_mid_after_b0_red", red0, SrcRed[0]);

    // A request raised and dropped between ticks leaves no trace
    SrcEn = 4'b1000;
    step(0);
    SrcEn = 4'b0000;
    step(1);
    check("glitch_sw", PW'(sw2), PW'(0));
    check("glitch_active", PW'(act2), PW'(0));
    check("glitch_b0_active", PW'(act0), PW'(0));

`ifdef FRAME_MUX_BLINK_EN
    // Blink, period 2, on the no-blank instance showing source 1
    RST       = 1'b1;
    SrcEn     = 4'b0010;
    BlinkMask = 4'b0010;
    step(0);
    RST = 1'b0;
    step(0);
    check("blink_f0_red", red0, SrcRed[0]);
    step(1);
    check("blink_f1_active", PW'(act0), PW'(1));
    check("blink_f1_red", red0, SrcRed[1]);
    step(0);
    check("blink_f1_hold", red0, SrcRed[1]);
    step(1);
    check("blink_f2_red", red0, PW'(0));
    check("blink_f2_grn", grn0, PW'(0));
    check("blink_f2_active", PW'(act0), PW'(1));
    step(1);
    check("blink_f3_red", red0, PW'(0));
    step(1);
    check("blink_f4_red", red0, SrcRed[1]);
    check("blink_f4_grn", grn0, SrcGrn[1]);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/frame_mux.md
# frame_mux

Parametrised successor to the game's fixed four-way pixel selector. It picks one of `NSRC` two-colour frame sources by priority of their enable lines and drives the LED-board driver's red and green planes. Source changes are deferred to frame boundaries and pass through a configurable blank interval. It sits between the game-state FSMs (screen generators) and the LED driver.

## Interface
- `ROWS`, default 16: frame rows.
- `COLS`, default 16: frame columns.
- `NSRC`, default 4: number of sources, at least 2; source 0 is the idle/reset screen.
- `BLANK_FRAMES`, default 2: frame ticks of all-dark output on a switch, 0..15.
- `BLINK_PERIOD`, default 8: frame ticks per blink half-period, at least 1; used only with the blink feature.
- `CLK` in, 1: system clock; the only clock.
- `RST` in, 1: reset, synchronous and active-high.
- `SrcRed` in, [NSRC][ROWS][COLS]: red plane per source.
- `SrcGrn` in, [NSRC][ROWS][COLS]: green plane per source.
- `SrcEn` in, [NSRC]: source requests. The highest set index wins; if none are set, source 0 is requested.
- `FrameTick` in, 1: one-cycle pulse at the driver's frame boundary.
- `BlinkMask` in, [NSRC]: source blinks when its bit is set. Present only with `FRAME_MUX_BLINK_EN`.
- `RedPixels` out, [ROWS][COLS]: registered red plane.
- `GrnPixels` out, [ROWS][COLS]: registered green plane.
- `Active` out, $clog2(NSRC): index of the source currently shown.
- `Switching` out, 1: high while in BLANK.

## Operation
- `req` is the combinational priority encode of `SrcEn`. It is sampled only on cycles where `FrameTick`=1.
- State registers: `state` (SHOW or BLANK), `cur`, `pend`, `bcnt`.
- SHOW state:
  - Outputs load `SrcRed[cur]` and `SrcGrn[cur]` every cycle (live data).
  - On `FrameTick` with `req`≠`cur` and `BLANK_FRAMES`>0: `pend`←`req`, `bcnt`←`BLANK_FRAMES`, go to BLANK.
  - On `FrameTick` with `req`≠`cur` and `BLANK_FRAMES`=0: `cur`←`req` directly, staying in SHOW.
- BLANK state:
  - Outputs are all zero.
  - On each `FrameTick`: `pend`←`req` (retarget to the latest request) and `bcnt` decrements. The interval is never restarted.
  - On the tick where `bcnt`=1: `cur`←`req`, go to SHOW.
  - If that `req` equals the old `cur`, the blank still completes and the old source returns.
- `FrameTick` in the same cycle as a SHOW/BLANK decision is consumed exactly once.
- `RST` has priority over everything. It aborts a blank in progress and takes effect on the same edge.
- `Active`=`cur` in both states. `Switching`=(`state`==BLANK).

## Timing
- Reset values:
  - `RedPixels`=0, `GrnPixels`=0.
  - `Active`=0, `Switching`=0.
  - `state`=SHOW, `cur`=`pend`=0, `bcnt`=0, blink phase=on, blink counter=0.
  - The cycle after `RST` falls, outputs show source 0 data.
- Source-data latency is 1 cycle: an input change at cycle t appears on the outputs after edge t.
- Switch timing: the edge that samples `FrameTick`=1 with `req`≠`cur` also sets the outputs to zero and `Switching`=1, all on that same edge.
- Blank duration: exactly `BLANK_FRAMES` ticks. New data appears on the edge of the `BLANK_FRAMES`-th subsequent tick.
- `SrcEn` changes between ticks have no effect.
- `Active` and the outputs always update on the same edge.

## Configuration
- `FRAME_MUX_BLINK_EN` defined:
  - Adds the `BlinkMask` port and a blink phase counter that counts `FrameTick` and toggles the phase every `BLINK_PERIOD` ticks. It is free-running and cleared only by `RST`.
  - In SHOW with `BlinkMask[cur]`=1 and phase off, both planes are zero. Phase changes take effect on the counting tick edge.
  - BLANK output is unaffected.
- `FRAME_MUX_BLINK_EN` undefined: no `BlinkMask` port, no counter, never blinks.

## Structure
- Package `frame_mux_pkg`:
  - `state_t` enum {SHOW, BLANK}.
  - Default `ROWS`/`COLS` constants (16) shared with the LED driver.
  - A `BLANK_FRAMES_MAX`=15 constant.
- One sub-module, `blink_phase_gen` (inputs `CLK`, `RST`, `FrameTick`; output `Phase`). It is instantiated only under `FRAME_MUX_BLINK_EN`.
- The priority encoder is a function in the package.

## Test plan
- Reset and default source:
  - `RST`=1 for 3 cycles with `SrcEn`=0 → outputs 0 and `Active`=0.
  - After `RST` falls → `RedPixels`=`SrcRed[0]` one cycle later.
- Deferred switch with blanking (`BLANK_FRAMES`=2):
  - `SrcEn`=4'b0100 mid-frame → no change until the next `FrameTick`.
  - Then outputs 0 and `Switching`=1 for 2 ticks.
  - On the 2nd tick edge, `Active`=2 with source 2 data.
- Priority and retarget:
  - `SrcEn`=4'b1010 → request is source 3.
  - During the blank, change to 4'b0010 → after the blank, `Active`=1, and the blank length is unchanged (2 ticks).
- Reset mid-blank:
  - `RST` pulse one cycle after entering BLANK → next edge `Switching`=0, `Active`=0, outputs 0.
- `BLANK_FRAMES`=0 build:
  - `SrcEn` change then `FrameTick` → `Active` and data switch on that edge; `Switching` never rises.
- `FRAME_MUX_BLINK_EN` build (`BLINK_PERIOD`=2, `BlinkMask[1]`=1, showing source 1):
  - Outputs are source data for ticks 0-1, zero for ticks 2-3, then repeat.
